// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
//   - state_e    : arbiter FSM states (IDLE / EXEC / RESP)
//   - OP_*       : 3-bit ALU operation encodings
//   - DATA_W     : datapath width (16)
//   - ERR_DATA   : result returned for modulo by zero
package alu_arb_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 3;

  localparam logic [DATA_W-1:0] ERR_DATA = 16'hFFFF;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_SHL = 3'b100;
  localparam logic [OP_W-1:0] OP_SHR = 3'b101;
  localparam logic [OP_W-1:0] OP_MUL = 3'b110;
  localparam logic [OP_W-1:0] OP_MOD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu: purely combinational 16-bit ALU, the arbiter's only arithmetic resource.
// Ports:
//   a_i, b_i  in  16  operands
//   op_i      in  3   operation select (see alu_arb_pkg OP_*)
//   y_o       out 16  result, low 16 bits
//   err_o     out 1   high only for modulo by zero
module alu
  import alu_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [DATA_W-1:0] y_o,
  output logic              err_o
);

  logic [2*DATA_W-1:0] prod;
  logic                shift_big;

  assign prod      = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
  // Any shift distance of 16 or more clears the whole word.
  assign shift_big = |b_i[DATA_W-1:4];

  always_comb begin
    y_o   = '0;
    err_o = 1'b0;
    case (op_i)
      OP_ADD: y_o = a_i + b_i;
      OP_SUB: y_o = a_i - b_i;
      OP_AND: y_o = a_i & b_i;
      OP_OR:  y_o = a_i | b_i;
      OP_SHL: y_o = shift_big ? '0 : (a_i << b_i[3:0]);
      OP_SHR: y_o = shift_big ? '0 : (a_i >> b_i[3:0]);
      OP_MUL: y_o = prod[DATA_W-1:0];
      OP_MOD: begin
        if (b_i == '0) begin
          y_o   = ERR_DATA;
          err_o = 1'b1;
        end else begin
          y_o = a_i % b_i;
        end
      end
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: arbitrates two requesters onto one shared ALU, one operation
// in flight at a time (IDLE -> EXEC -> RESP -> IDLE).
// Configuration macro: ALU_ARB_RR_EN
//   defined   -> round-robin arbitration with a one-bit pointer
//   undefined -> fixed priority, requester 0 wins, no pointer register
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid[1:0]             per-requester valid
//   req_ready[1:0]             per-requester accept (one-hot or zero)
//   req_a0/b0/op0, req_a1/b1/op1  operands and op per requester
//   rsp_valid, rsp_ready       response handshake
//   rsp_data, rsp_id, rsp_err  response payload
//   busy                       high whenever not IDLE
//   dbg_state                  current FSM state, for observation only
//
// Handshake rule (both request and response sides): a transfer happens on a
// rising edge where valid and ready are both high. Ready may depend
// combinationally on valid; payload must stay stable while valid && !ready.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [OP_W-1:0]   req_op0,
  input  logic [OP_W-1:0]   req_op1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  output logic              rsp_err,
  output logic              busy,
  output state_e            dbg_state
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, b_q;
  logic [OP_W-1:0]   op_q;
  logic              id_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;

  logic              gnt;
  logic              accept;
  logic [DATA_W-1:0] alu_y;
  logic              alu_err;

  // ---------------- arbitration ----------------
`ifdef ALU_ARB_RR_EN
  logic ptr_q;

  // Pointer breaks ties only; a lone valid requester always wins.
  always_comb begin
    if (&req_valid) gnt = ptr_q;
    else            gnt = req_valid[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr_q <= 1'b0;
    else if (accept) ptr_q <= ~ptr_q;
  end
`else
  // Requester 0 wins whenever it is valid.
  always_comb begin
    gnt = ~req_valid[0];
  end
`endif

  assign accept = |(req_valid & req_ready);

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_EXEC;
      ST_EXEC:                state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && req_valid[gnt]) req_ready[gnt] = 1'b1;
    rsp_valid = (state_q == ST_RESP);
    busy      = (state_q != ST_IDLE);
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      id_q <= 1'b0;
    end else if (accept) begin
      a_q  <= gnt ? req_a1  : req_a0;
      b_q  <= gnt ? req_b1  : req_b0;
      op_q <= gnt ? req_op1 : req_op0;
      id_q <= gnt;
    end
  end

  // Result is captured only in EXEC, so it stays frozen through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      rsp_data_q <= alu_y;
      rsp_err_q  <= alu_err;
    end
  end

  alu u_alu (
    .a_i   (a_q),
    .b_i   (b_q),
    .op_i  (op_q),
    .y_o   (alu_y),
    .err_o (alu_err)
  );

  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_id    = id_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic, checked
// cycle by cycle against a transaction-level reference model.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a0, req_b0, req_a1, req_b1;
  logic [2:0]  req_op0, req_op1;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_id, rsp_err, busy;
  state_e      dbg_state;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .req_op0   (req_op0),
    .req_op1   (req_op1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected responses, packed as {err, id, data}.
  logic [17:0] exp_q[$];
  int          grant_log[$];
  // Cycles since acceptance of the operation in flight; -1 when idle.
  int          age    = -1;
  int          rr_ptr = 0;
  logic [15:0] last_data;
  logic        last_err;

  // Result per the operation definitions, using plain integer arithmetic.
  function automatic logic [16:0] ref_alu(input int a, input int b, input int op);
    longint r;
    logic   e;
    e = 1'b0;
    case (op)
      0: r = a + b;
      1: r = a - b + 65536;
      2: r = a & b;
      3: r = a | b;
      4: r = (b >= 16) ? 0 : longint'(a) * (longint'(1) << b);
      5: r = (b >= 16) ? 0 : a / (1 << b);
      6: r = longint'(a) * longint'(b);
      default: begin
        if (b == 0) begin r = 65535; e = 1'b1; end
        else r = a % b;
      end
    endcase
    return {e, 16'(r % 65536)};
  endfunction

  // Winner among valid requesters, -1 if none.
  function automatic int pick(input logic [1:0] v);
    if (v == 2'b00) return -1;
`ifdef ALU_ARB_RR_EN
    if (v == 2'b11) return rr_ptr;
`endif
    return v[0] ? 0 : 1;
  endfunction

  // ---------------- driver tasks ----------------
  // One clock cycle: entered just after a falling edge with inputs set.
  task automatic step();
    int          g;
    logic [1:0]  er;
    logic [17:0] e;
    logic [16:0] r;
    g = -1;
    #1;
    if (age < 0) begin
      g  = pick(req_valid);
      er = (g < 0) ? 2'b00 : (2'b01 << g);
      check("idle_req_ready", req_ready, er);
      check("idle_rsp_valid", rsp_valid, 1'b0);
      check("idle_busy", busy, 1'b0);
    end else begin
      check("busy_req_ready", req_ready, 2'b00);
      check("busy_busy", busy, 1'b1);
      check("rsp_valid_timing", rsp_valid, (age >= 2));
      if (age >= 2) begin
        if (exp_q.size() == 0) begin
          check("exp_q_empty", 32'd0, 32'd1);
        end else begin
          e = exp_q[0];
          check("rsp_data", rsp_data, e[15:0]);
          check("rsp_id", rsp_id, e[16]);
          check("rsp_err", rsp_err, e[17]);
        end
      end
    end
    // advance the model across the coming rising edge
    if (age < 0) begin
      if (g >= 0) begin
        if (g == 0) r = ref_alu(int'(req_a0), int'(req_b0), int'(req_op0));
        else        r = ref_alu(int'(req_a1), int'(req_b1), int'(req_op1));
        exp_q.push_back({r[16], 1'(g), r[15:0]});
        grant_log.push_back(g);
        rr_ptr = 1 - rr_ptr;
        age    = 1;
      end
    end else if (age == 1) begin
      age = 2;
    end else if (rsp_ready) begin
      last_data = rsp_data;
      last_err  = rsp_err;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      age = -1;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 16'h0000);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_req_ready", req_ready, 2'b00);
    age    = -1;
    rr_ptr = 0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int r, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op);
    if (r == 0) begin req_a0 = a; req_b0 = b; req_op0 = op; end
    else        begin req_a1 = a; req_b1 = b; req_op1 = op; end
  endtask

  // Single operation from requester r with the consumer always ready.
  task automatic run_op(input int r, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] op);
    set_req(r, a, b, op);
    req_valid = 2'b01 << r;
    rsp_ready = 1'b1;
    step();
    req_valid = 2'b00;
    for (int i = 0; i < 10 && age >= 0; i++) step();
    if (age >= 0) check("run_op_timeout", 32'd1, 32'd0);
  endtask

  task automatic rand_inputs();
    req_valid = 2'($urandom_range(0, 3));
    req_a0    = 16'($urandom);
    req_a1    = 16'($urandom);
    req_b0    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
    req_b1    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
    req_op0   = 3'($urandom_range(0, 7));
    req_op1   = 3'($urandom_range(0, 7));
    rsp_ready = ($urandom_range(0, 2) != 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    req_a0 = '0; req_b0 = '0; req_op0 = '0;
    req_a1 = '0; req_b1 = '0; req_op1 = '0;
    apply_reset();

    // single add from requester 0
    run_op(0, 16'd3, 16'd5, OP_ADD);
    check("add_data", last_data, 16'd8);
    check("add_err", last_err, 1'b0);

    // modulo, by zero and by three
    run_op(1, 16'd7, 16'd0, OP_MOD);
    check("mod0_data", last_data, 16'hFFFF);
    check("mod0_err", last_err, 1'b1);
    run_op(1, 16'd7, 16'd3, OP_MOD);
    check("mod3_data", last_data, 16'd1);
    check("mod3_err", last_err, 1'b0);

    // overflow and shift boundaries
    run_op(0, 16'h0100, 16'h0100, OP_MUL);
    check("mul_ovf", last_data, 16'h0000);
    run_op(0, 16'd1, 16'd16, OP_SHL);
    check("shl16", last_data, 16'h0000);
    run_op(1, 16'd0, 16'd1, OP_SUB);
    check("sub_wrap", last_data, 16'hFFFF);
    check("sub_err", last_err, 1'b0);

    // contention: both valid for four operations
    apply_reset();
    grant_log.delete();
    set_req(0, 16'd10, 16'd1, OP_ADD);
    set_req(1, 16'd20, 16'd2, OP_SUB);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && grant_log.size() < 4; i++) step();
    req_valid = 2'b00;
    for (int i = 0; i < 10 && age >= 0; i++) step();
    check("contention_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
`ifdef ALU_ARB_RR_EN
      check($sformatf("contention_gnt%0d", i), grant_log[i], i % 2);
`else
      check($sformatf("contention_gnt%0d", i), grant_log[i], 0);
`endif
    end

    // backpressure: consumer stalls five cycles in RESP
    set_req(0, 16'h1234, 16'h0F0F, OP_AND);
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    step();
    req_valid = 2'b11;
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_in_resp", age, 2);
      step();
    end
    rsp_ready = 1'b1;
    step();
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    step();
    check("bp_result", last_data, 16'h0204);

    // reset during EXEC discards the operation
    set_req(1, 16'd9, 16'd9, OP_MUL);
    req_valid = 2'b10;
    rsp_ready = 1'b1;
    step();
    check("pre_reset_exec", dbg_state, ST_EXEC);
    apply_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      step();
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    for (int i = 0; i < 10 && age >= 0; i++) step();
    check("drain_idle", age, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: NREQ, default 2, number of requesters (fixed at 2 in this release; other values are not supported).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  2  per-requester request valid; bit i belongs to requester i.
REQ-006 req_ready  out  2  per-requester accept; one-hot or zero.
REQ-007 req_a0, req_b0, req_a1, req_b1  in  16 each  operands for requesters 0 and 1.
REQ-008 req_op0, req_op1  in  3 each  ALU select: 000 add, 001 sub, 010 and, 011 or, 100 shl, 101 shr, 110 mul, 111 mod.
REQ-009 rsp_valid  out  1  response valid.
REQ-010 rsp_ready  in  1  response consumer accept.
REQ-011 rsp_data  out  16  result, truncated to the low 16 bits.
REQ-012 rsp_id  out  1  requester index that owns the response.
REQ-013 rsp_err  out  1  set on mod by zero.
REQ-014 busy  out  1  high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, EXEC and RESP, with exactly one operation outstanding at any time.
REQ-016 In IDLE, req_ready SHALL assert combinationally only for the granted requester, and only when that requester's req_valid is high.
REQ-017 A handshake (valid and ready both high) SHALL latch a, b, op and the grant index, then move the FSM to EXEC on the next edge.
REQ-018 EXEC SHALL last exactly one cycle: it drives the shared ALU from the latched operands, registers the result into rsp_data, and moves to RESP.
REQ-019 In RESP, rsp_valid SHALL be high and rsp_data, rsp_id and rsp_err SHALL be held stable until rsp_ready is high; the FSM then returns to IDLE.
REQ-020 Latency SHALL be as follows: accept at edge T, rsp_valid high from edge T+2, and the next accept no earlier than one cycle after the rsp handshake.
REQ-021 For op 111 with b == 0, rsp_data SHALL be 16'hFFFF and rsp_err SHALL be 1; in all other cases rsp_err SHALL be 0.
REQ-022 For shift ops, b >= 16 SHALL yield 16'h0000.
REQ-023 For mul, the result SHALL be the low 16 bits of the product.
REQ-024 While not in IDLE, req_ready SHALL be 2'b00 and pending requests SHALL wait without being dropped.
REQ-025 A requester that deasserts valid before it is granted SHALL lose nothing; there is no request memory inside the block.

Reset
REQ-026 Asserting rst_n low SHALL immediately force state IDLE, rsp_valid 0, rsp_data 0, rsp_id 0, rsp_err 0, busy 0, and the round-robin pointer to requester 0.
REQ-027 Reset asserted in the middle of an operation SHALL discard that operation; no response is produced after reset is released.

Configuration
REQ-028 Macro ALU_ARB_RR_EN SHALL select the arbitration scheme.
REQ-029 With ALU_ARB_RR_EN defined: round-robin arbitration; the pointer moves to the other requester after each accepted request; when both are valid, the pointer's requester wins; when one is valid, it wins.
REQ-030 Without ALU_ARB_RR_EN: fixed priority, with requester 0 always winning over requester 1, and the pointer register is not implemented.

Structure
REQ-031 A shared package alu_arb_pkg SHALL hold the state enum (IDLE/EXEC/RESP), the 3-bit op encodings, the data width 16, and the error constant 16'hFFFF.
REQ-032 The block SHALL instantiate exactly one sub-module, the existing 16-bit ALU alu, as its only arithmetic resource.

Verification
REQ-033 Single add: requester 0 sends a=3, b=5, op=000 -> rsp_valid at T+2 with rsp_data=8, rsp_id=0, rsp_err=0.
REQ-034 Mod by zero: requester 1 sends a=7, b=0, op=111 -> rsp_data=16'hFFFF and rsp_err=1; a=7, b=3 -> rsp_data=1 and rsp_err=0.
REQ-035 Contention with ALU_ARB_RR_EN: both requesters hold valid for 4 ops -> grants alternate 0,1,0,1; without the macro -> grants are 0,0,0,0 and requester 1 stays waiting.
REQ-036 Backpressure: rsp_ready held low for 5 cycles -> rsp outputs stable, req_ready=00 and busy=1 throughout; after rsp_ready rises -> IDLE the next cycle.
REQ-037 Overflow and shift: mul 16'h0100 x 16'h0100 -> 16'h0000; shl a=1, b=16 -> 16'h0000; sub 0-1 -> 16'hFFFF with rsp_err=0.
REQ-038 Reset in EXEC: rst_n pulsed low during EXEC -> all outputs zero immediately and no rsp_valid after release.
